// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller and the memory address register.
package mem_ctrl_pkg;

    localparam int unsigned MEM_ADDR_W = 22;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StAccess = 2'd2,
        StDone   = 2'd3
    } mem_state_e;

    typedef enum logic {
        OWN_B = 1'b0,
        OWN_C = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the ACCESS phase; flags the cycle in which the count reaches TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] Limit = 8'(TIMEOUT);

    logic [7:0] count_q;
    logic [7:0] count_inc;

    assign count_inc = count_q + 8'd1;

    // Asserted in the cycle whose increment brings the count to TIMEOUT, so the
    // FSM leaves ACCESS after exactly TIMEOUT cycles without ready.
    assign expired = en && (count_inc == Limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (clr) begin
            count_q <= 8'd0;
        end else if (en) begin
            count_q <= count_inc;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates BUS B / BUS C memory accesses, sequences MAR load and rd/wr strobes, returns ack/err.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned RR_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic b_req,
    input  logic b_we,
    input  logic c_req,
    input  logic c_we,
    input  logic mem_ready,
    output logic busb_in,
    output logic busc_in,
    output logic mem_rd,
    output logic mem_wr,
    output logic b_ack,
    output logic c_ack,
    output logic err,
    output logic busy
);

    import mem_ctrl_pkg::*;

    mem_state_e state_q, state_d;
    owner_e     own_q, own_d;
    logic       we_q, we_d;
    logic       err_q, err_d;
    logic       last_c_q, last_c_d;
    logic       tmr_clr, tmr_en, tmr_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        we_d     = we_q;
        err_d    = err_q;
        last_c_d = last_c_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (b_req || c_req) begin
                    if (b_req && c_req && (RR_MODE != 0)) begin
                        own_d = last_c_q ? OWN_B : OWN_C;
                    end else begin
                        own_d = b_req ? OWN_B : OWN_C;
                    end
                    we_d    = (own_d == OWN_B) ? b_we : c_we;
                    err_d   = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                tmr_clr = 1'b1;
                state_d = StAccess;
            end
            StAccess: begin
                // Ready takes precedence over a simultaneous timeout.
                if (mem_ready) begin
                    err_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                last_c_d = (own_q == OWN_C);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are flopped from the next-state decode so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            own_q    <= OWN_B;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            last_c_q <= 1'b1;
            busb_in  <= 1'b0;
            busc_in  <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            b_ack    <= 1'b0;
            c_ack    <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            we_q     <= we_d;
            err_q    <= err_d;
            last_c_q <= last_c_d;
            busb_in  <= (state_d == StLoad) && (own_d == OWN_B);
            busc_in  <= (state_d == StLoad) && (own_d == OWN_C);
            mem_rd   <= (state_d == StAccess) && !we_d;
            mem_wr   <= (state_d == StAccess) && we_d;
            b_ack    <= (state_d == StDone) && (own_d == OWN_B);
            c_ack    <= (state_d == StDone) && (own_d == OWN_C);
            err      <= (state_d == StDone) && err_d;
            busy     <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (fixed priority / TIMEOUT 15, round-robin / TIMEOUT 3)
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic b_req = 1'b0, b_we = 1'b0, c_req = 1'b0, c_we = 1'b0, mem_ready = 1'b0;

    logic busb0, busc0, rd0, wr0, back0, cack0, err0, busy0;
    logic busb1, busc1, rd1, wr1, back1, cack1, err1, busy1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(15), .RR_MODE(0)) u0 (
        .clk(clk), .reset(reset), .b_req(b_req), .b_we(b_we), .c_req(c_req), .c_we(c_we),
        .mem_ready(mem_ready), .busb_in(busb0), .busc_in(busc0), .mem_rd(rd0), .mem_wr(wr0),
        .b_ack(back0), .c_ack(cack0), .err(err0), .busy(busy0)
    );

    mem_access_ctrl #(.TIMEOUT(3), .RR_MODE(1)) u1 (
        .clk(clk), .reset(reset), .b_req(b_req), .b_we(b_we), .c_req(c_req), .c_we(c_we),
        .mem_ready(mem_ready), .busb_in(busb1), .busc_in(busc1), .mem_rd(rd1), .mem_wr(wr1),
        .b_ack(back1), .c_ack(cack1), .err(err1), .busy(busy1)
    );

    logic [7:0] dout [2];
    assign dout[0] = {busb0, busc0, rd0, wr0, back0, cack0, err0, busy0};
    assign dout[1] = {busb1, busc1, rd1, wr1, back1, cack1, err1, busy1};

    // Transaction-level model: age counts cycles since the grant (1 = load, 2 = accessing).
    int unsigned m_age [2];
    int unsigned m_wait [2];
    bit m_own [2];    // 1 = C
    bit m_we [2];
    bit m_done [2];
    bit m_err [2];
    bit m_last_c [2];
    logic [7:0] exp_o [2];
    bit model_ok = 1'b0;

    function automatic int unsigned tmo_of(input int i);
        return (i == 0) ? 15 : 3;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_age[i] = 0; m_done[i] = 1'b0; m_last_c[i] = 1'b1; m_wait[i] = 0;
            end else if (m_done[i]) begin
                m_last_c[i] = m_own[i]; m_done[i] = 1'b0; m_age[i] = 0;
            end else if (m_age[i] == 0) begin
                if (b_req || c_req) begin
                    if (b_req) m_own[i] = (c_req && i == 1) ? !m_last_c[i] : 1'b0;
                    else m_own[i] = 1'b1;
                    m_we[i] = m_own[i] ? c_we : b_we;
                    m_age[i] = 1;
                end
            end else if (m_age[i] == 1) begin
                m_age[i] = 2; m_wait[i] = 0;
            end else if (mem_ready) begin
                m_done[i] = 1'b1; m_err[i] = 1'b0;
            end else begin
                m_wait[i]++;
                if (m_wait[i] == tmo_of(i)) begin
                    m_done[i] = 1'b1; m_err[i] = 1'b1;
                end
            end
            exp_o[i] = 8'h00;
            if (m_done[i]) begin
                exp_o[i][3] = !m_own[i]; exp_o[i][2] = m_own[i];
                exp_o[i][1] = m_err[i];  exp_o[i][0] = 1'b1;
            end else if (m_age[i] == 1) begin
                exp_o[i][7] = !m_own[i]; exp_o[i][6] = m_own[i]; exp_o[i][0] = 1'b1;
            end else if (m_age[i] >= 2) begin
                exp_o[i][5] = !m_we[i]; exp_o[i][4] = m_we[i]; exp_o[i][0] = 1'b1;
            end
        end
        if (reset) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dout[i] !== exp_o[i]) begin
                    bad++;
                    $display("FAIL model_cmp u%0d t=%0t got=%b want=%b", i, $time, dout[i],
                             exp_o[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        b_req = 0; c_req = 0; b_we = 0; c_we = 0; mem_ready = 0;
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        // Reset state
        reset = 1;
        step();
        chk("reset_out_u0", |dout[0], 1'b0);
        chk("reset_out_u1", |dout[1], 1'b0);
        do_reset();

        // Single read, fast memory
        b_req = 1; b_we = 0; mem_ready = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t1_busb", busb0, k == 1);
            chk("t1_rd", rd0, k == 2);
            chk("t1_back", back0, k == 3);
            chk("t1_err", err0, 1'b0);
            chk("t1_busc_wr", busc0 | wr0, 1'b0);
            if (k == 3) b_req = 0;
        end

        // Simultaneous requests held continuously
        do_reset();
        b_req = 1; c_req = 1; b_we = 0; c_we = 1; mem_ready = 1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("t2_fixed_back", back0, (k % 4) == 3);
            chk("t2_fixed_cack", cack0, 1'b0);
            chk("t2_fixed_strobes", busb0 & busc0, 1'b0);
            chk("t2_rr_back", back1, ((k % 4) == 3) && ((k / 4) % 2 == 0));
            chk("t2_rr_cack", cack1, ((k % 4) == 3) && ((k / 4) % 2 == 1));
            chk("t2_rr_strobes", busb1 & busc1, 1'b0);
        end
        b_req = 0; c_req = 0;

        // C write with wait states, ready on the 5th access cycle
        do_reset();
        c_req = 1; c_we = 1; mem_ready = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("t3_busc", busc0, k == 1);
            chk("t3_wr", wr0, (k >= 2) && (k <= 6));
            chk("t3_cack", cack0, k == 7);
            chk("t3_err", err0, 1'b0);
            chk("t3_busb_rd", busb0 | rd0, 1'b0);
            if (k == 6) mem_ready = 1;
            if (k == 7) begin
                mem_ready = 0; c_req = 0;
            end
        end

        // Timeout with no ready
        do_reset();
        b_req = 1; b_we = 0; mem_ready = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("t4_rd_u1", rd1, (k >= 2) && (k <= 4));
            chk("t4_back_u1", back1, k == 5);
            chk("t4_err_u1", err1, k == 5);
            chk("t4_back_u0", back0, k == 17);
            chk("t4_err_u0", err0, k == 17);
            if (k == 5) b_req = 0;
        end

        // Ready in the cycle the count reaches TIMEOUT
        do_reset();
        b_req = 1; b_we = 0; mem_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t4b_rd_u1", rd1, (k >= 2) && (k <= 4));
            chk("t4b_back_u1", back1, k == 5);
            chk("t4b_err_u1", err1, 1'b0);
            if (k == 4) mem_ready = 1;
            if (k == 5) begin
                mem_ready = 0; b_req = 0;
            end
        end

        // Reset during the 2nd access cycle
        do_reset();
        b_req = 1; b_we = 1; mem_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t5_busb", busb0, (k == 1) || (k == 5));
            chk("t5_wr", wr0, (k == 2) || (k == 3) || (k == 6));
            chk("t5_back", back0, k == 7);
            chk("t5_err", err0, 1'b0);
            if (k == 4) begin
                chk("t5_zero_u0", |dout[0], 1'b0);
                chk("t5_zero_u1", |dout[1], 1'b0);
            end
            if (k == 3) reset = 1;
            if (k == 4) reset = 0;
            if (k == 5) mem_ready = 1;
            if (k == 7) begin
                mem_ready = 0; b_req = 0;
            end
        end

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
